// File: rtl/posit_encoder_if.sv
// Handshake and field bundle between an unpacked-posit producer and posit_encoder.
// Signal names follow the encoder's port list so the producer side reads naturally.
interface posit_encoder_if #(
  parameter int n  = 16,
  parameter int es = 1
);
  localparam int nd         = $clog2(n - 1);
  localparam int EXP_WIDTH  = nd + es;
  localparam int MANT_WIDTH = n - es - 3;

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  nar_i;
  logic                  sign_i;
  logic [EXP_WIDTH:0]    rg_exp_i;
  logic [MANT_WIDTH:0]   mant_norm_i;
  logic                  sticky_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [n-1:0]          posit_o;

  modport master (
    output in_valid_i, nar_i, sign_i, rg_exp_i, mant_norm_i, sticky_i, out_ready_i,
    input  in_ready_o, out_valid_o, posit_o
  );

  modport slave (
    input  in_valid_i, nar_i, sign_i, rg_exp_i, mant_norm_i, sticky_i, out_ready_i,
    output in_ready_o, out_valid_o, posit_o
  );
endinterface

// File: rtl/posit_encoder.sv
// Two-stage posit packer: stage 1 classifies and sizes the regime, stage 2 shifts,
// rounds to nearest-even, saturates and applies sign/special-value overrides.
module posit_encoder #(
  parameter int n  = 16,
  parameter int es = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  posit_encoder_if.slave    bus
);
  localparam int nd         = $clog2(n - 1);
  localparam int EXP_WIDTH  = nd + es;
  localparam int MANT_WIDTH = n - es - 3;
  localparam int BODY_W     = n - 3;
  localparam int PAD_W      = 2 * n - 2 - BODY_W;
  localparam int SAT_SCALE  = (n - 2) << es;

  localparam logic [n-1:0] MAXPOS = {1'b0, {(n - 1){1'b1}}};
  localparam logic [n-1:0] MINPOS = {{(n - 1){1'b0}}, 1'b1};
  localparam logic [n-1:0] NAR    = {1'b1, {(n - 1){1'b0}}};

  function automatic logic [n-1:0] negate(input logic [n-1:0] v);
    return ~v + MINPOS;
  endfunction

  // ---------------- stage 1: classify, size regime ----------------
  logic                 in_ready_s, s2_ready_s;
  int                   rg_int_s, k_int_s;
  logic                 zero_s, hi_s, lo_s, neg_s;
  logic [EXP_WIDTH-1:0] shamt_s;
  logic [BODY_W-1:0]    body_s;

  logic                 s1_v_r, s1_sign_r, s1_nar_r, s1_zero_r, s1_hi_r, s1_lo_r, s1_neg_r, s1_sticky_r;
  logic [EXP_WIDTH-1:0] s1_shamt_r;
  logic [BODY_W-1:0]    s1_body_r;
  logic                 s2_v_r;
  logic [n-1:0]         s2_posit_r;

  assign s2_ready_s = ~s2_v_r | bus.out_ready_i;
  assign in_ready_s = ~s1_v_r | s2_ready_s;

  // Exponent bits sit directly above the fraction; with es=0 the body is just the fraction.
  if (es > 0) begin : g_body_es
    assign body_s = {bus.rg_exp_i[es-1:0], bus.mant_norm_i[MANT_WIDTH-1:0]};
  end else begin : g_body_noes
    assign body_s = bus.mant_norm_i[MANT_WIDTH-1:0];
  end

  // Scale decode: regime k, saturation/zero flags and regime shift amount.
  always_comb begin
    rg_int_s = int'($signed(bus.rg_exp_i));
    k_int_s  = rg_int_s >>> es;
    zero_s   = ~bus.mant_norm_i[MANT_WIDTH] & ~bus.nar_i;
    hi_s     = (rg_int_s >= SAT_SCALE);
    lo_s     = (rg_int_s < -SAT_SCALE);
    neg_s    = (k_int_s < 0);
    if (neg_s) begin
      shamt_s = EXP_WIDTH'(-k_int_s - 1);
    end else begin
      shamt_s = EXP_WIDTH'(k_int_s);
    end
  end

  // Stage 1 register; advances whenever stage 2 can take its contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_r      <= 1'b0;
      s1_sign_r   <= 1'b0;
      s1_nar_r    <= 1'b0;
      s1_zero_r   <= 1'b0;
      s1_hi_r     <= 1'b0;
      s1_lo_r     <= 1'b0;
      s1_neg_r    <= 1'b0;
      s1_sticky_r <= 1'b0;
      s1_shamt_r  <= {EXP_WIDTH{1'b0}};
      s1_body_r   <= {BODY_W{1'b0}};
    end else if (in_ready_s) begin
      s1_v_r <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_sign_r   <= bus.sign_i;
        s1_nar_r    <= bus.nar_i;
        s1_zero_r   <= zero_s;
        s1_hi_r     <= hi_s;
        s1_lo_r     <= lo_s;
        s1_neg_r    <= neg_s;
        s1_sticky_r <= bus.sticky_i;
        s1_shamt_r  <= shamt_s;
        s1_body_r   <= body_s;
      end
    end
  end

  // ---------------- stage 2: shift, round, clamp ----------------
  logic [2*n-1:0] w0_s, ws_s;
  logic [n-2:0]   mag_s;
  logic           guard_s, sticky_s;
  logic [n-1:0]   sum_s, clamp_s, posit_s;

  // Negative k: "01" prefix shifted logically gives -k zeros then 1.
  // Non-negative k: "10" prefix shifted arithmetically gives k+1 ones then 0.
  always_comb begin
    w0_s = {(s1_neg_r ? 2'b01 : 2'b10), s1_body_r, {PAD_W{1'b0}}};
    if (s1_neg_r) begin
      ws_s = w0_s >> s1_shamt_r;
    end else begin
      ws_s = $unsigned($signed(w0_s) >>> s1_shamt_r);
    end
    mag_s    = ws_s[2*n-1 -: n-1];
    guard_s  = ws_s[n];
    sticky_s = (|ws_s[n-1:0]) | s1_sticky_r;
    sum_s    = {1'b0, mag_s} + {{(n - 1){1'b0}}, guard_s & (mag_s[0] | sticky_s)};
    if (sum_s[n-1]) begin
      clamp_s = MAXPOS;
    end else if (sum_s == {n{1'b0}}) begin
      clamp_s = MINPOS;
    end else begin
      clamp_s = sum_s;
    end

    if (s1_nar_r) begin
      posit_s = NAR;
    end else if (s1_zero_r) begin
      posit_s = {n{1'b0}};
    end else if (s1_hi_r) begin
      posit_s = s1_sign_r ? negate(MAXPOS) : MAXPOS;
    end else if (s1_lo_r) begin
      posit_s = s1_sign_r ? negate(MINPOS) : MINPOS;
    end else begin
      posit_s = s1_sign_r ? negate(clamp_s) : clamp_s;
    end
  end

  // Output register; holds steady while downstream stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_v_r     <= 1'b0;
      s2_posit_r <= {n{1'b0}};
    end else if (s2_ready_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        s2_posit_r <= posit_s;
      end
    end
  end

  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = s2_v_r;
  assign bus.posit_o     = s2_posit_r;
endmodule
